stream_pe_chain: RTL and testbench

// - Parametrised successor to the fixed six-PE data_path: a chain of NUM_COL elastic PE columns.
// - Each column applies a lane-wise integer op to a PHIT_SIZE-bit stream of LANES = PHIT_SIZE/DWIDTH words.
// - Has valid/ready backpressure, a beat-counted run FSM and per-column scalar register files.
// - Sits between the stream ingress and egress; FP columns remain in a separate IP-based datapath.

---
 rtl/stream_pe_pkg.sv | 16 +
 rtl/stream_pe_stage.sv | 108 ++++++++++
 rtl/stream_pe_chain.sv | 166 ++++++++++++++++
 tb/tb_stream_pe_chain.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pe_pkg.sv
// Shared types for the stream PE chain: lane ops, operand-B sources,
// run FSM states and the lane-count helper.
package stream_pe_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MAX, OP_PASS} op_e;

  typedef enum logic [1:0] {SEL_IMM, SEL_RF, SEL_ITR, SEL_ZERO} sel_e;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // Number of DWIDTH-bit words carried by one PHIT_SIZE-bit beat.
  function automatic int lanes(input int phit_size, input int dwidth);
    return phit_size / dwidth;
  endfunction

endpackage

// File: rtl/stream_pe_stage.sv
// One PE column: elastic {valid, data} register, lane-wise integer ALU
// and a small scalar register file supplying operand B.
// Optional iterator operand enabled by macro STREAM_PE_CHAIN_ITR_EN.
module stream_pe_stage
  import stream_pe_pkg::*;
#(
  parameter int PHIT_SIZE = 512,
  parameter int DWIDTH    = 64,
  parameter int RF_DEPTH  = 16,
`ifdef STREAM_PE_CHAIN_ITR_EN
  parameter int LEN_W     = 16,
`endif
  localparam int RF_AWIDTH = $clog2(RF_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           sel,
  input  logic [1:0]           op,
  input  logic [DWIDTH-1:0]    imm,
  input  logic [RF_AWIDTH-1:0] rd_addr,
`ifdef STREAM_PE_CHAIN_ITR_EN
  input  logic [DWIDTH-1:0]    itr_base,
  input  logic [LEN_W-1:0]     in_idx,
  output logic [LEN_W-1:0]     out_idx,
`endif
  input  logic                 rf_wen,
  input  logic [RF_AWIDTH-1:0] rf_addr,
  input  logic [DWIDTH-1:0]    rf_wdata,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PHIT_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PHIT_SIZE-1:0] out_data
);

  localparam int LANES = lanes(PHIT_SIZE, DWIDTH);

  logic [DWIDTH-1:0]    rf [RF_DEPTH];
  logic [PHIT_SIZE-1:0] alu;

  // The register can load whenever it is empty or its content leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  // Lane ALU: operand B selection then the configured op, all mod 2^DWIDTH.
  always_comb begin
    alu = '0;
    for (int j = 0; j < LANES; j++) begin
      logic [DWIDTH-1:0] x;
      logic [DWIDTH-1:0] b;
      logic [DWIDTH-1:0] r;
      x = in_data[j*DWIDTH +: DWIDTH];
      b = '0;
      r = x;
      case (sel_e'(sel))
        SEL_IMM:  b = imm;
        SEL_RF:   b = rf[rd_addr];
`ifdef STREAM_PE_CHAIN_ITR_EN
        SEL_ITR:  b = itr_base + DWIDTH'(in_idx) * DWIDTH'(LANES) + DWIDTH'(j);
`else
        SEL_ITR:  b = '0;
`endif
        SEL_ZERO: b = '0;
        default:  b = '0;
      endcase
      case (op_e'(op))
        OP_ADD:  r = x + b;
        OP_SUB:  r = x - b;
        OP_MAX:  r = ($signed(x) > $signed(b)) ? x : b;
        OP_PASS: r = x;
        default: r = x;
      endcase
      alu[j*DWIDTH +: DWIDTH] = r;
    end
  end

  // Elastic stage register; data only changes when a new beat is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= alu;
    end
  end

`ifdef STREAM_PE_CHAIN_ITR_EN
  // Beat index rides alongside its beat so the iterator sees the right i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_idx <= '0;
    end else if (in_ready && in_valid) begin
      out_idx <= in_idx;
    end
  end
`endif

  // Host register file write; the top gates rf_wen to IDLE and this column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (rf_wen) begin
      rf[rf_addr] <= rf_wdata;
    end
  end

endmodule

// File: rtl/stream_pe_chain.sv
// Chain of NUM_COL elastic PE columns with a beat-counted run FSM.
// Optional iterator operand enabled by macro STREAM_PE_CHAIN_ITR_EN.
//
// Handshake: a beat moves across any interface (s_*, m_*, and between
// stages) on a rising edge where valid && ready are both high. valid never
// depends on ready of the same interface; once valid is raised by a stage it
// holds with unchanged data until the transfer. ready may depend on valid.
module stream_pe_chain
  import stream_pe_pkg::*;
#(
  parameter int PHIT_SIZE = 512,
  parameter int DWIDTH    = 64,
  parameter int NUM_COL   = 4,
  parameter int RF_DEPTH  = 16,
  parameter int LEN_W     = 16,
  localparam int RF_AWIDTH = $clog2(RF_DEPTH),
  localparam int COL_W     = $clog2(NUM_COL)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_W-1:0]               len,
  output logic                           busy,
  output logic                           done,
  input  logic [NUM_COL*2-1:0]           cfg_sel,
  input  logic [NUM_COL*2-1:0]           cfg_op,
  input  logic [NUM_COL*DWIDTH-1:0]      cfg_imm,
  input  logic [NUM_COL*RF_AWIDTH-1:0]   cfg_rd_addr,
  input  logic [DWIDTH-1:0]              itr_base,
  input  logic                           rf_wen,
  input  logic [COL_W-1:0]               rf_col,
  input  logic [RF_AWIDTH-1:0]           rf_addr,
  input  logic [DWIDTH-1:0]              rf_wdata,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [PHIT_SIZE-1:0]           s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [PHIT_SIZE-1:0]           m_data,
  output logic [1:0]                     dbg_state
);

  state_e                         state, state_n;
  logic [LEN_W-1:0]               beat_cnt, beat_n;
  logic [LEN_W-1:0]               len_q;
  logic                           cap;
  logic [NUM_COL*2-1:0]           sel_q;
  logic [NUM_COL*2-1:0]           op_q;
  logic [NUM_COL*DWIDTH-1:0]      imm_q;
  logic [NUM_COL*RF_AWIDTH-1:0]   rd_q;

  logic [NUM_COL:0]               vld;
  logic [NUM_COL:0]               rdy;
  logic [PHIT_SIZE-1:0]           dat [NUM_COL+1];
  logic                           accept;
  logic                           any_valid;

`ifdef STREAM_PE_CHAIN_ITR_EN
  logic [DWIDTH-1:0]              itr_q;
  logic [LEN_W-1:0]               idx [NUM_COL+1];
  assign idx[0] = beat_cnt;
`else
  logic                           unused_itr;
  assign unused_itr = ^itr_base;
`endif

  assign s_ready   = (state == RUN) && rdy[0];
  assign accept    = s_valid && s_ready;
  assign vld[0]    = accept;
  assign dat[0]    = s_data;
  assign rdy[NUM_COL] = m_ready;
  assign m_valid   = vld[NUM_COL];
  assign m_data    = dat[NUM_COL];
  assign any_valid = |vld[NUM_COL:1];
  assign busy      = (state != IDLE);
  assign done      = (state == DRAIN) && !any_valid;
  assign dbg_state = state;

  // Next-state logic: launch, count accepted beats, wait for the pipe to empty.
  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap     = 1'b1;
          beat_n  = '0;
          state_n = (len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          beat_n = beat_cnt + LEN_W'(1);
          if (beat_cnt == len_q - LEN_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!any_valid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, beat counter and run configuration captured on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
      sel_q    <= '0;
      op_q     <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
`ifdef STREAM_PE_CHAIN_ITR_EN
      itr_q    <= '0;
`endif
    end else begin
      state    <= state_n;
      beat_cnt <= beat_n;
      if (cap) begin
        len_q <= len;
        sel_q <= cfg_sel;
        op_q  <= cfg_op;
        imm_q <= cfg_imm;
        rd_q  <= cfg_rd_addr;
`ifdef STREAM_PE_CHAIN_ITR_EN
        itr_q <= itr_base;
`endif
      end
    end
  end

  for (genvar k = 0; k < NUM_COL; k++) begin : g_col
    stream_pe_stage #(
      .PHIT_SIZE (PHIT_SIZE),
      .DWIDTH    (DWIDTH),
`ifdef STREAM_PE_CHAIN_ITR_EN
      .LEN_W     (LEN_W),
`endif
      .RF_DEPTH  (RF_DEPTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel_q[k*2 +: 2]),
      .op        (op_q[k*2 +: 2]),
      .imm       (imm_q[k*DWIDTH +: DWIDTH]),
      .rd_addr   (rd_q[k*RF_AWIDTH +: RF_AWIDTH]),
`ifdef STREAM_PE_CHAIN_ITR_EN
      .itr_base  (itr_q),
      .in_idx    (idx[k]),
      .out_idx   (idx[k+1]),
`endif
      .rf_wen    (rf_wen && (state == IDLE) && (rf_col == COL_W'(k))),
      .rf_addr   (rf_addr),
      .rf_wdata  (rf_wdata),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_data   (dat[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_data  (dat[k+1])
    );
  end

endmodule

// File: tb/tb_stream_pe_chain.sv
// Directed testbench for stream_pe_chain (default parameters, 8 lanes).
// Covers STREAM_PE_CHAIN_ITR_EN both defined and undefined.
module tb_stream_pe_chain;

  localparam int PW = 512;
  localparam int DW = 64;
  localparam int NC = 4;
  localparam int NL = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     len = '0;
  logic            busy, done;
  logic [NC*2-1:0] cfg_sel = '0;
  logic [NC*2-1:0] cfg_op = '0;
  logic [NC*DW-1:0] cfg_imm = '0;
  logic [NC*4-1:0] cfg_rd_addr = '0;
  logic [DW-1:0]   itr_base = '0;
  logic            rf_wen = 1'b0;
  logic [1:0]      rf_col = '0;
  logic [3:0]      rf_addr = '0;
  logic [DW-1:0]   rf_wdata = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [PW-1:0]   s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [PW-1:0]   m_data;
  logic [1:0]      dbg_state;

  logic [PW-1:0]   exp_q[$];
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  int              acc_cnt = 0;
  int              out_cnt = 0;
  int              first_acc = -1;
  int              first_mv = -1;
  logic            sr_seen = 1'b0;

  stream_pe_chain dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .cfg_sel(cfg_sel), .cfg_op(cfg_op), .cfg_imm(cfg_imm), .cfg_rd_addr(cfg_rd_addr),
    .itr_base(itr_base), .rf_wen(rf_wen), .rf_col(rf_col), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL global_timeout cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rep(input logic [DW-1:0] v);
    return {NL{v}};
  endfunction

  // scoreboard: monitor sampling on the falling edge
  always @(negedge clk) begin
    if (s_ready) sr_seen = 1'b1;
    if (s_valid && s_ready) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (m_valid && first_mv < 0) first_mv = cyc;
    if (m_valid && m_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL out_unexpected: observed %0h expected no beat", m_data);
      end else begin
        chk("out_beat", m_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic set_col(input int k, input logic [1:0] sel, input logic [1:0] op,
                         input logic [DW-1:0] imm, input logic [3:0] rd);
    cfg_sel[k*2 +: 2]    = sel;
    cfg_op[k*2 +: 2]     = op;
    cfg_imm[k*DW +: DW]  = imm;
    cfg_rd_addr[k*4 +: 4] = rd;
  endtask

  task automatic all_pass();
    for (int k = 0; k < NC; k++) set_col(k, 2'b11, 2'b11, '0, '0);
  endtask

  task automatic start_run(input int n);
    len = 16'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic rf_write(input int c, input int a, input logic [DW-1:0] d);
    rf_col = 2'(c); rf_addr = 4'(a); rf_wdata = d; rf_wen = 1'b1;
    @(posedge clk); #1;
    rf_wen = 1'b0;
  endtask

  task automatic feed_beat(input logic [PW-1:0] d);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && t < 200) begin @(negedge clk); t++; end
    if (!s_ready) begin
      tests++; fails++;
      $error("FAIL feed_timeout: observed s_ready=0 expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [DW-1:0] base, input logic [DW-1:0] inc);
    for (int i = 0; i < n; i++) feed_beat(rep(base + inc * 64'(i)));
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 200) begin @(negedge clk); t++; end
    chk({tag, "_done"}, done, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  logic [PW-1:0] v0, v1;

  initial begin
    // reset
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_state", dbg_state, 2'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // smoke: all add imm=1, lane 3 -> 7, latency 4
    for (int k = 0; k < NC; k++) set_col(k, 2'b00, 2'b00, 64'd1, '0);
    first_acc = -1; first_mv = -1; out_cnt = 0;
    repeat (3) exp_q.push_back(rep(64'd7));
    start_run(3);
    chk("smoke_busy", busy, 1'b1);
    feed(3, 64'd3, 64'd0);
    wait_done("smoke");
    chk("smoke_latency", first_mv - first_acc, 4);
    chk("smoke_out_cnt", out_cnt, 3);

    // backpressure: pass, distinct beats, m_ready low 10 cycles
    all_pass();
    acc_cnt = 0; out_cnt = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(rep(64'd100 + 64'(i)));
    m_ready = 1'b0;
    start_run(8);
    fork
      feed(8, 64'd100, 64'd1);
      begin
        repeat (10) @(posedge clk);
        #1;
        chk("bp_acc_cnt", acc_cnt, 4);
        chk("bp_s_ready_low", s_ready, 1'b0);
        chk("bp_m_valid_held", m_valid, 1'b1);
        chk("bp_m_data_held", m_data, rep(64'd100));
        m_ready = 1'b1;
      end
    join
    wait_done("bp");
    chk("bp_out_cnt", out_cnt, 8);

    // wrap: col0 sub imm=1, lane 0 -> all ones
    all_pass();
    set_col(0, 2'b00, 2'b01, 64'd1, '0);
    exp_q.push_back(rep(64'hFFFF_FFFF_FFFF_FFFF));
    start_run(1);
    feed(1, 64'd0, 64'd0);
    wait_done("wrap");

    // RF max (signed): RF[1][5]=10, lane -4 -> 10
    rf_write(1, 5, 64'd10);
    all_pass();
    set_col(1, 2'b01, 2'b10, '0, 4'd5);
    exp_q.push_back(rep(64'd10));
    start_run(1);
    feed(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    wait_done("rfmax");
    // write during RUN must be ignored: max(-4, 3) would give 3
    exp_q.push_back(rep(64'd10));
    start_run(1);
    rf_write(1, 5, 64'd3);
    feed(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    wait_done("rf_run_wen");

    // len = 0: done one cycle after start, s_ready never high
    sr_seen = 1'b0; out_cnt = 0;
    len = 16'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b1);
    @(posedge clk); #1;
    chk("len0_done_low", done, 1'b0);
    chk("len0_idle", busy, 1'b0);
    chk("len0_s_ready_seen", sr_seen, 1'b0);
    chk("len0_out_cnt", out_cnt, 0);

    // start outside IDLE ignored: len=1 run, second start with len=5 mid-run
    exp_q.push_back(rep(64'd44));
    start_run(1);
    start_run(5);
    feed(1, 64'd44, 64'd0);
    wait_done("start_ignored");

    // async reset mid-RUN
    start_run(8);
    s_valid = 1'b1;
    s_data  = rep(64'd5);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b0);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_m_data", m_data, '0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_state", dbg_state, 2'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    // after reset RF is zero: col1 max(-4, RF=0) -> 0 confirms RF cleared
    all_pass();
    set_col(0, 2'b00, 2'b00, 64'd2, '0);
    set_col(1, 2'b01, 2'b10, '0, 4'd5);
    exp_q.push_back(rep(64'd0));
    exp_q.push_back(rep(64'd9));
    start_run(2);
    feed(1, 64'hFFFF_FFFF_FFFF_FFFA, 64'd0);
    feed(1, 64'd7, 64'd0);
    wait_done("post_rst");

    // iterator: col0 add/itr, base 100, lanes 0, len 2
    all_pass();
    set_col(0, 2'b10, 2'b00, '0, '0);
    itr_base = 64'd100;
    for (int j = 0; j < NL; j++) begin
`ifdef STREAM_PE_CHAIN_ITR_EN
      v0[j*DW +: DW] = 64'd100 + 64'(j);
      v1[j*DW +: DW] = 64'd108 + 64'(j);
`else
      v0[j*DW +: DW] = 64'd0;
      v1[j*DW +: DW] = 64'd0;
`endif
    end
    exp_q.push_back(v0);
    exp_q.push_back(v1);
    start_run(2);
    feed(2, 64'd0, 64'd0);
    wait_done("itr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
